regfile_wport_arb: RTL and testbench
====================================

Name: regfile_wport_arb

Overview:
Sequences the single register-file write port between the in-order WB stage and a long-latency multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO and drained into idle WB slots.
- A 32-entry scoreboard tracks destination registers with MDU results still outstanding, so the hazard unit can stall dependent instructions in ID.
- A starvation guard requests a pipeline hold when the MDU FIFO cannot drain.

Parameters:
FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
STARVE_LIMIT, 4, consecutive blocked cycles of a non-empty FIFO before o_wb_hold asserts

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-low reset
i_wb_wren  in  1  WB stage write request
i_wb_rd  in  5  WB destination register
i_wb_data  in  32  WB write data
i_mdu_valid  in  1  MDU result valid
o_mdu_ready  out  1  FIFO can accept an MDU result
i_mdu_rd  in  5  MDU destination register
i_mdu_data  in  32  MDU result
i_iss_valid  in  1  MDU op issued from ID this cycle
i_iss_rd  in  5  destination of the issued MDU op
i_rs1_addr  in  5  ID source 1
i_rs2_addr  in  5  ID source 2
o_rs1_busy  out  1  rs1 has an outstanding MDU write
o_rs2_busy  out  1  rs2 has an outstanding MDU write
o_rd_wren  out  1  write enable to register file
o_rd_addr  out  5  write address to register file
o_rd_data  out  32  write data to register file
o_wb_hold  out  1  request: freeze pipeline so WB is idle next cycle

Behaviour:
- Reset (async, active-low): FIFO empty, scoreboard all 0, starve counter 0, o_wb_hold=0. Consequently o_mdu_ready=1 and o_rd_wren=0.
- Write-port mux (combinational):
  - WB active means i_wb_wren=1 and i_wb_rd≠0.
  - If WB is active and o_wb_hold=0: pass WB through.
  - Else if FIFO is non-empty: output the FIFO head and pop it this edge.
  - Else: o_rd_wren=0.
  - A WB write to x0 counts as idle.
- FIFO accept:
  - o_mdu_ready = (count < FIFO_DEPTH), computed from registered count only. There is no same-cycle pop credit.
  - Push on i_mdu_valid & o_mdu_ready.
  - Simultaneous push and pop: count unchanged.
  - Results with i_mdu_rd=0 are accepted and dropped (never pushed).
  - Minimum latency from MDU accept to register-file write: 1 cycle.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the head is blocked by WB.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- o_wb_hold:
  - Registered; set the cycle after the counter reaches STARVE_LIMIT.
  - Cleared on the edge the head pops.
  - While o_wb_hold=1 the FIFO head has priority on the port. A simultaneous active WB request is an integration error and must be caught by an assertion; its write is lost.
- Scoreboard: 32-bit pending vector.
  - Set pending[i_iss_rd] on i_iss_valid with i_iss_rd≠0.
  - Clear pending[rd] when a FIFO entry with that rd is written to the port.
  - Set and clear on the same rd in the same cycle: set wins.
  - i_iss_valid to an rd that is already pending is illegal (assertion); the hazard unit must stall it.
  - WB writes never clear pending.
- Busy outputs:
  - o_rsN_busy = pending[rsN] & (rsN≠0) & ~(FIFO draining rd==rsN this cycle).
  - The same-cycle drain term matches the register file's internal write-to-read forwarding.

Decomposition:
- Package regfile_arb_pkg holds:
  - typedef reg_addr_t (5 bits) and typedef xlen_t (32 bits)
  - struct wr_req_t {rd, data}
  - constant REG_X0
- Sub-module wport_fifo: synchronous FIFO of wr_req_t with FIFO_DEPTH entries, count output, registered full/empty, async active-low reset.
- Scoreboard and arbiter logic live in the top module.

Test Plan:
- Reset mid-operation: 2 entries queued and pending[5]=1, then assert i_reset → o_mdu_ready=1, o_rd_wren=0, busy=0, o_wb_hold=0 immediately.
- Idle drain: issue rd=7, then MDU result rd=7 data=0xDEADBEEF with WB idle → write appears 1 cycle after accept. o_rs1_busy (rs1=7) is 1 until the write cycle, 0 during it.
- WB priority: continuous WB writes to x3 while the MDU pushes rd=9 → WB wins. o_wb_hold rises after 4 blocked cycles; next cycle x9 is written and hold drops.
- FIFO full: two MDU results with WB busy → o_mdu_ready=0. A third valid is held off until one pop; no data loss, writes occur in order.
- x0 handling: WB rd=0 with FIFO non-empty → FIFO head drains that cycle. MDU result rd=0 is dropped, count unchanged, no write.
- Same-cycle set and clear: drain rd=12 while issuing rd=12 → pending[12] stays 1. o_rs2_busy(12)=0 that cycle, 1 the next.

Source files
------------

// File: rtl/regfile_wport_arb_pkg.sv
// Shared types for the register-file write-port arbiter: register address,
// data word and the queued write request.
package regfile_arb_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } wr_req_t;

  localparam reg_addr_t REG_X0 = 5'd0;

  // Writes to x0 are architecturally discarded, so they never count as real traffic.
  function automatic logic is_live(input reg_addr_t addr);
    return addr != REG_X0;
  endfunction

endpackage

// File: rtl/regfile_wport_arb_fifo.sv
// Synchronous FIFO of pending MDU write requests; full/empty are registered
// so the accept decision never depends on the same-cycle pop.
module wport_fifo
  import regfile_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  wr_req_t       i_din,
  input  logic          i_pop,
  output wr_req_t       o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  wr_req_t       mem_q [DEPTH];
  wr_req_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push, pop;

  assign push = i_push & ~full_q;
  assign pop  = i_pop & ~empty_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = i_din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

// File: rtl/regfile_wport_arb.sv
// Shares the single register-file write port between WB and buffered MDU
// results, tracks outstanding MDU destinations and requests a pipeline hold on starvation.
module regfile_wport_arb
  import regfile_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_wb_wren,
  input  reg_addr_t i_wb_rd,
  input  xlen_t     i_wb_data,
  input  logic      i_mdu_valid,
  output logic      o_mdu_ready,
  input  reg_addr_t i_mdu_rd,
  input  xlen_t     i_mdu_data,
  input  logic      i_iss_valid,
  input  reg_addr_t i_iss_rd,
  input  reg_addr_t i_rs1_addr,
  input  reg_addr_t i_rs2_addr,
  output logic      o_rs1_busy,
  output logic      o_rs2_busy,
  output logic      o_rd_wren,
  output reg_addr_t o_rd_addr,
  output xlen_t     o_rd_data,
  output logic      o_wb_hold
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          hold_q, hold_d;
  logic [31:0]   pending_q, pending_d;

  logic          wb_active;
  logic          fifo_push, fifo_pop;
  wr_req_t       fifo_din, fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  assign wb_active   = i_wb_wren & is_live(i_wb_rd);
  assign o_mdu_ready = (fifo_count < CW'(FIFO_DEPTH));
  // Results for x0 are acknowledged but never occupy a slot.
  assign fifo_push   = i_mdu_valid & o_mdu_ready & is_live(i_mdu_rd);
  assign fifo_pop    = ~fifo_empty & (~wb_active | hold_q);
  assign fifo_din    = '{rd: i_mdu_rd, data: i_mdu_data};

  wport_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (fifo_push),
    .i_din   (fifo_din),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    o_rd_wren = 1'b0;
    o_rd_addr = REG_X0;
    o_rd_data = '0;
    if (wb_active && !hold_q) begin
      o_rd_wren = 1'b1;
      o_rd_addr = i_wb_rd;
      o_rd_data = i_wb_data;
    end else if (fifo_pop) begin
      o_rd_wren = 1'b1;
      o_rd_addr = fifo_head.rd;
      o_rd_data = fifo_head.data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_pop || fifo_empty) begin
      starve_d = '0;
    end else if (wb_active && !hold_q && starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
    // Hold goes up on the same edge the blocked run reaches the limit.
    hold_d = !fifo_pop && (hold_q || starve_d == SW'(STARVE_LIMIT));
  end

  always_comb begin
    pending_d = pending_q;
    if (fifo_pop) begin
      pending_d[fifo_head.rd] = 1'b0;
    end
    if (i_iss_valid && is_live(i_iss_rd)) begin
      pending_d[i_iss_rd] = 1'b1;
    end
  end

  // The drain term mirrors the register file's write-to-read bypass.
  assign o_rs1_busy = pending_q[i_rs1_addr] & is_live(i_rs1_addr) &
                      ~(fifo_pop && fifo_head.rd == i_rs1_addr);
  assign o_rs2_busy = pending_q[i_rs2_addr] & is_live(i_rs2_addr) &
                      ~(fifo_pop && fifo_head.rd == i_rs2_addr);
  assign o_wb_hold  = hold_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      starve_q  <= '0;
      hold_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      starve_q  <= starve_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
    end
  end

  a_no_wb_during_hold : assert property (@(posedge i_clk) disable iff (!i_reset)
    !(hold_q && wb_active));

  a_no_reissue_pending : assert property (@(posedge i_clk) disable iff (!i_reset)
    !(i_iss_valid && is_live(i_iss_rd) && pending_q[i_iss_rd] &&
      !(fifo_pop && fifo_head.rd == i_iss_rd)));

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// queue-based reference model of the write-port arbiter.
module tb_regfile_wport_arb;
  import regfile_arb_pkg::*;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic      i_clk = 1'b0;
  logic      i_reset;
  logic      i_wb_wren;
  reg_addr_t i_wb_rd;
  xlen_t     i_wb_data;
  logic      i_mdu_valid;
  logic      o_mdu_ready;
  reg_addr_t i_mdu_rd;
  xlen_t     i_mdu_data;
  logic      i_iss_valid;
  reg_addr_t i_iss_rd;
  reg_addr_t i_rs1_addr;
  reg_addr_t i_rs2_addr;
  logic      o_rs1_busy;
  logic      o_rs2_busy;
  logic      o_rd_wren;
  reg_addr_t o_rd_addr;
  xlen_t     o_rd_data;
  logic      o_wb_hold;

  int errors = 0;
  int checks = 0;

  regfile_wport_arb #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_wb_wren   (i_wb_wren),
    .i_wb_rd     (i_wb_rd),
    .i_wb_data   (i_wb_data),
    .i_mdu_valid (i_mdu_valid),
    .o_mdu_ready (o_mdu_ready),
    .i_mdu_rd    (i_mdu_rd),
    .i_mdu_data  (i_mdu_data),
    .i_iss_valid (i_iss_valid),
    .i_iss_rd    (i_iss_rd),
    .i_rs1_addr  (i_rs1_addr),
    .i_rs2_addr  (i_rs2_addr),
    .o_rs1_busy  (o_rs1_busy),
    .o_rs2_busy  (o_rs2_busy),
    .o_rd_wren   (o_rd_wren),
    .o_rd_addr   (o_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_wb_hold   (o_wb_hold)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: queue of results waiting for the port, pending set,
  // length of the current blocked run and the hold request.
  wr_req_t     mq[$];
  logic [31:0] mpend;
  int          mrun;
  bit          mhold;

  bit        e_wren, e_ready, e_b1, e_b2, e_pop, e_push, e_blocked, e_iss;
  reg_addr_t e_addr, c_mdu_rd, c_iss_rd;
  xlen_t     e_data, c_mdu_data;

  task automatic model_reset();
    mq.delete();
    mpend = '0;
    mrun  = 0;
    mhold = 1'b0;
  endtask

  task automatic model_eval();
    bit wb_act;
    wb_act    = i_wb_wren && i_wb_rd != 5'd0;
    e_ready   = mq.size() < FIFO_DEPTH;
    e_pop     = mq.size() > 0 && (!wb_act || mhold);
    e_blocked = mq.size() > 0 && wb_act && !mhold;
    e_push    = i_mdu_valid && e_ready && i_mdu_rd != 5'd0;
    e_iss     = i_iss_valid && i_iss_rd != 5'd0;
    c_mdu_rd  = i_mdu_rd;
    c_mdu_data = i_mdu_data;
    c_iss_rd  = i_iss_rd;
    e_wren = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    if (wb_act && !mhold) begin
      e_wren = 1'b1; e_addr = i_wb_rd; e_data = i_wb_data;
    end else if (e_pop) begin
      e_wren = 1'b1; e_addr = mq[0].rd; e_data = mq[0].data;
    end
    e_b1 = i_rs1_addr != 5'd0 && mpend[i_rs1_addr] && !(e_pop && mq[0].rd == i_rs1_addr);
    e_b2 = i_rs2_addr != 5'd0 && mpend[i_rs2_addr] && !(e_pop && mq[0].rd == i_rs2_addr);
  endtask

  task automatic model_update();
    bit      was_empty;
    wr_req_t t;
    was_empty = mq.size() == 0;
    if (e_pop) begin
      mpend[mq[0].rd] = 1'b0;
      void'(mq.pop_front());
    end
    if (e_push) begin
      t.rd = c_mdu_rd; t.data = c_mdu_data;
      mq.push_back(t);
    end
    if (e_iss) mpend[c_iss_rd] = 1'b1;
    if (e_pop || was_empty) mrun = 0;
    else if (e_blocked && mrun < STARVE_LIMIT) mrun++;
    mhold = !e_pop && (mhold || mrun >= STARVE_LIMIT);
  endtask

  task automatic step();
    model_eval();
    @(posedge i_clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    i_wb_wren = 0; i_wb_rd = 0; i_wb_data = 0;
    i_mdu_valid = 0; i_mdu_rd = 0; i_mdu_data = 0;
    i_iss_valid = 0; i_iss_rd = 0; i_rs1_addr = 0; i_rs2_addr = 0;
  endtask

  task automatic apply_reset();
    set_idle();
    i_reset = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge i_clk);
    checks++; if (o_mdu_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", o_mdu_ready); end
    checks++; if (o_rd_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got=%b exp=0", o_rd_wren); end
    checks++; if (o_wb_hold !== 1'b0) begin errors++; $display("FAIL rst_hold got=%b exp=0", o_wb_hold); end
    step();
    i_wb_wren = 1; i_wb_rd = 3; i_wb_data = 32'h33; i_iss_valid = 1; i_iss_rd = 5;
    i_mdu_valid = 1; i_mdu_rd = 20; i_mdu_data = 32'h20;
    step();
    i_iss_valid = 0; i_mdu_rd = 21; i_mdu_data = 32'h21;
    step();
    i_mdu_valid = 0; i_rs1_addr = 5;
    @(negedge i_clk);
    checks++; if (o_mdu_ready !== 1'b0) begin errors++; $display("FAIL pre_rst_ready got=%b exp=0", o_mdu_ready); end
    checks++; if (o_rs1_busy !== 1'b1) begin errors++; $display("FAIL pre_rst_busy got=%b exp=1", o_rs1_busy); end
    #2;
    i_reset = 1'b0; i_wb_wren = 0;
    #1;
    checks++; if (o_mdu_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", o_mdu_ready); end
    checks++; if (o_rd_wren !== 1'b0) begin errors++; $display("FAIL midrst_wren got=%b exp=0", o_rd_wren); end
    checks++; if (o_rs1_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", o_rs1_busy); end
    checks++; if (o_wb_hold !== 1'b0) begin errors++; $display("FAIL midrst_hold got=%b exp=0", o_wb_hold); end
    model_reset();
    @(posedge i_clk);
    #1 i_reset = 1'b1;
  endtask

  task automatic test_idle_drain();
    apply_reset();
    i_iss_valid = 1; i_iss_rd = 7; i_rs1_addr = 7;
    @(negedge i_clk);
    checks++; if (o_rs1_busy !== 1'b0) begin errors++; $display("FAIL drain_busy_c0 got=%b exp=0", o_rs1_busy); end
    step();
    i_iss_valid = 0; i_mdu_valid = 1; i_mdu_rd = 7; i_mdu_data = 32'hDEADBEEF;
    @(negedge i_clk);
    checks++; if (o_rs1_busy !== 1'b1) begin errors++; $display("FAIL drain_busy_c1 got=%b exp=1", o_rs1_busy); end
    checks++; if (o_rd_wren !== 1'b0) begin errors++; $display("FAIL drain_wren_c1 got=%b exp=0", o_rd_wren); end
    step();
    i_mdu_valid = 0;
    @(negedge i_clk);
    checks++; if ({o_rd_wren, o_rd_addr, o_rd_data} !== {1'b1, 5'd7, 32'hDEADBEEF})
      begin errors++; $display("FAIL drain_write got=%b/%0d/%h exp=1/7/deadbeef", o_rd_wren, o_rd_addr, o_rd_data); end
    checks++; if (o_rs1_busy !== 1'b0) begin errors++; $display("FAIL drain_busy_c2 got=%b exp=0", o_rs1_busy); end
    step();
    @(negedge i_clk);
    checks++; if (o_rs1_busy !== 1'b0 || o_rd_wren !== 1'b0)
      begin errors++; $display("FAIL drain_after got busy=%b wren=%b exp=0/0", o_rs1_busy, o_rd_wren); end
    step();
  endtask

  task automatic test_wb_priority();
    apply_reset();
    i_wb_wren = 1; i_wb_rd = 3; i_wb_data = 32'h3333; i_iss_valid = 1; i_iss_rd = 9; i_rs1_addr = 9;
    step();
    i_iss_valid = 0; i_mdu_valid = 1; i_mdu_rd = 9; i_mdu_data = 32'h99990000;
    step();
    i_mdu_valid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      checks++; if (o_rd_addr !== 5'd3 || o_rd_wren !== 1'b1 || o_wb_hold !== 1'b0)
        begin errors++; $display("FAIL prio_blocked c%0d got addr=%0d wren=%b hold=%b exp=3/1/0", c, o_rd_addr, o_rd_wren, o_wb_hold); end
      step();
    end
    i_wb_wren = 0;
    @(negedge i_clk);
    checks++; if (o_wb_hold !== 1'b1) begin errors++; $display("FAIL prio_hold got=%b exp=1", o_wb_hold); end
    checks++; if ({o_rd_wren, o_rd_addr, o_rd_data} !== {1'b1, 5'd9, 32'h99990000})
      begin errors++; $display("FAIL prio_drain got=%b/%0d/%h exp=1/9/99990000", o_rd_wren, o_rd_addr, o_rd_data); end
    step();
    @(negedge i_clk);
    checks++; if (o_wb_hold !== 1'b0 || o_rs1_busy !== 1'b0)
      begin errors++; $display("FAIL prio_release got hold=%b busy=%b exp=0/0", o_wb_hold, o_rs1_busy); end
    step();
  endtask

  task automatic test_fifo_full();
    xlen_t exp_d[3];
    exp_d = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
    apply_reset();
    i_wb_wren = 1; i_wb_rd = 3; i_wb_data = 32'h3;
    i_mdu_valid = 1; i_mdu_rd = 10; i_mdu_data = exp_d[0];
    step();
    i_mdu_rd = 11; i_mdu_data = exp_d[1];
    @(negedge i_clk);
    checks++; if (o_mdu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_c1 got=%b exp=1", o_mdu_ready); end
    step();
    i_mdu_rd = 13; i_mdu_data = exp_d[2];
    for (int c = 2; c < 5; c++) begin
      @(negedge i_clk);
      checks++; if (o_mdu_ready !== 1'b0) begin errors++; $display("FAIL full_ready c%0d got=%b exp=0", c, o_mdu_ready); end
      step();
    end
    i_wb_wren = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      checks++; if ({o_rd_wren, o_rd_addr, o_rd_data} !== {1'b1, (k == 2) ? 5'd13 : 5'(10 + k), exp_d[k]})
        begin errors++; $display("FAIL full_order k%0d got=%b/%0d/%h exp data=%h", k, o_rd_wren, o_rd_addr, o_rd_data, exp_d[k]); end
      if (k == 1) begin
        checks++; if (o_mdu_ready !== 1'b1) begin errors++; $display("FAIL full_reopen got=%b exp=1", o_mdu_ready); end
      end
      step();
      if (k == 1) i_mdu_valid = 0;
    end
    @(negedge i_clk);
    checks++; if (o_rd_wren !== 1'b0) begin errors++; $display("FAIL full_empty_wren got=%b exp=0", o_rd_wren); end
    step();
  endtask

  task automatic test_x0();
    apply_reset();
    i_wb_wren = 1; i_wb_rd = 3; i_mdu_valid = 1; i_mdu_rd = 14; i_mdu_data = 32'h14141414;
    step();
    i_mdu_valid = 0; i_wb_rd = 0; i_wb_data = 32'hFFFFFFFF;
    @(negedge i_clk);
    checks++; if ({o_rd_wren, o_rd_addr, o_rd_data} !== {1'b1, 5'd14, 32'h14141414})
      begin errors++; $display("FAIL x0_wb_idle got=%b/%0d/%h exp=1/14/14141414", o_rd_wren, o_rd_addr, o_rd_data); end
    step();
    i_wb_wren = 0; i_mdu_valid = 1; i_mdu_rd = 0; i_mdu_data = 32'h0BAD0BAD;
    @(negedge i_clk);
    checks++; if (o_mdu_ready !== 1'b1) begin errors++; $display("FAIL x0_accept got=%b exp=1", o_mdu_ready); end
    step();
    i_mdu_valid = 0;
    @(negedge i_clk);
    checks++; if (o_rd_wren !== 1'b0 || o_mdu_ready !== 1'b1)
      begin errors++; $display("FAIL x0_dropped got wren=%b ready=%b exp=0/1", o_rd_wren, o_mdu_ready); end
    step();
  endtask

  task automatic test_same_cycle();
    apply_reset();
    i_iss_valid = 1; i_iss_rd = 12; i_rs2_addr = 12;
    step();
    i_iss_valid = 0; i_mdu_valid = 1; i_mdu_rd = 12; i_mdu_data = 32'h12;
    @(negedge i_clk);
    checks++; if (o_rs2_busy !== 1'b1) begin errors++; $display("FAIL same_busy_pre got=%b exp=1", o_rs2_busy); end
    step();
    i_mdu_valid = 0; i_iss_valid = 1; i_iss_rd = 12;
    @(negedge i_clk);
    checks++; if (o_rs2_busy !== 1'b0 || o_rd_addr !== 5'd12 || o_rd_wren !== 1'b1)
      begin errors++; $display("FAIL same_drain got busy=%b addr=%0d wren=%b exp=0/12/1", o_rs2_busy, o_rd_addr, o_rd_wren); end
    step();
    i_iss_valid = 0;
    @(negedge i_clk);
    checks++; if (o_rs2_busy !== 1'b1) begin errors++; $display("FAIL same_set_wins got=%b exp=1", o_rs2_busy); end
    step();
  endtask

  task automatic test_random();
    reg_addr_t r;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      i_wb_wren   = ($urandom_range(0, 99) < 60) && !mhold;
      i_wb_rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      i_wb_data   = $urandom;
      i_mdu_valid = $urandom_range(0, 99) < 40;
      i_mdu_rd    = 5'($urandom_range(0, 7));
      i_mdu_data  = $urandom;
      r           = 5'($urandom_range(1, 7));
      i_iss_valid = ($urandom_range(0, 99) < 30) && !mpend[r];
      i_iss_rd    = r;
      i_rs1_addr  = 5'($urandom_range(0, 7));
      i_rs2_addr  = 5'($urandom_range(0, 7));
      @(negedge i_clk);
      model_eval();
      checks++; if (o_rd_wren !== e_wren || (e_wren && (o_rd_addr !== e_addr || o_rd_data !== e_data)))
        begin errors++; $display("FAIL rnd_port c%0d got=%b/%0d/%h exp=%b/%0d/%h", c, o_rd_wren, o_rd_addr, o_rd_data, e_wren, e_addr, e_data); end
      checks++; if (o_mdu_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, o_mdu_ready, e_ready); end
      checks++; if (o_rs1_busy !== e_b1 || o_rs2_busy !== e_b2)
        begin errors++; $display("FAIL rnd_busy c%0d got=%b%b exp=%b%b", c, o_rs1_busy, o_rs2_busy, e_b1, e_b2); end
      checks++; if (o_wb_hold !== mhold) begin errors++; $display("FAIL rnd_hold c%0d got=%b exp=%b", c, o_wb_hold, mhold); end
      step();
    end
  endtask

  initial begin
    set_idle();
    i_reset = 1'b0;
    test_reset();
    test_idle_drain();
    test_wb_priority();
    test_fifo_full();
    test_x0();
    test_same_cycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
